// File: rtl/comparitor_pkg.sv
// comparitor_pkg: shared FSM encoding, flag positions and selector constants
package comparitor_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_e;
  localparam int FLAG_EQ = 0;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 2;
  localparam int SEL_NO_LOAD = 0;
endpackage

// File: rtl/comparitor_scheduler_arbiter.sv
// round_robin_arbiter: picks the first set request at or after the pointer, wrapping
module round_robin_arbiter #(
  parameter int REQUESTERS = 4
) (
  input  logic [REQUESTERS-1:0]         req_i,
  input  logic [$clog2(REQUESTERS)-1:0] ptr_i,
  output logic [REQUESTERS-1:0]         onehot_o,
  output logic [$clog2(REQUESTERS)-1:0] id_o,
  output logic                          valid_o
);
  localparam int IW = $clog2(REQUESTERS);
  logic [IW-1:0] idx;
  // scan from farthest to nearest so the nearest set request wins
  always_comb begin
    id_o = '0;
    idx = '0;
    for (int k = REQUESTERS - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_i) + k) % REQUESTERS);
      if (req_i[idx]) id_o = idx;
    end
  end
  assign valid_o = |req_i;
  assign onehot_o = valid_o ? REQUESTERS'(1) << id_o : '0;
endmodule

// File: rtl/comparitor_scheduler.sv
// comparitor_scheduler: round-robin sharing of one fixed-latency comparitor unit
module comparitor_scheduler
  import comparitor_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int COUNT0 = 4,
  parameter int COUNT1 = 4,
  parameter int RESULT_LATENCY = 2,
  localparam int W0 = $clog2(COUNT0 + 1),
  localparam int W1 = $clog2(COUNT1 + 1),
  localparam int IW = $clog2(REQUESTERS),
  localparam int CW = $clog2(RESULT_LATENCY + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [REQUESTERS-1:0]    req_valid,
  input  logic [REQUESTERS*W0-1:0] req_sel0,
  input  logic [REQUESTERS*W1-1:0] req_sel1,
  output logic [REQUESTERS-1:0]    grant,
  output logic [W0-1:0]            cmp_selector0,
  output logic [W1-1:0]            cmp_selector1,
  input  logic                     cmp_eq,
  input  logic                     cmp_gt,
  input  logic                     cmp_lt,
  output logic                     rsp_valid,
  output logic [IW-1:0]            rsp_id,
  output logic                     rsp_eq,
  output logic                     rsp_gt,
  output logic                     rsp_lt,
  output logic                     rsp_error,
  output logic                     busy
);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d;
  logic [REQUESTERS-1:0] gnt_q, gnt_d;
  logic [W0-1:0] sel0_q, sel0_d;
  logic [W1-1:0] sel1_q, sel1_d;
  logic rej_q, rej_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] flags_q, flags_d;
  logic [REQUESTERS-1:0] arb_onehot;
  logic [IW-1:0] arb_id;
  logic arb_valid;
  logic [W0-1:0] sel0_v [REQUESTERS];
  logic [W1-1:0] sel1_v [REQUESTERS];
  for (genvar i = 0; i < REQUESTERS; i++) begin : g_unpack
    assign sel0_v[i] = req_sel0[i*W0 +: W0];
    assign sel1_v[i] = req_sel1[i*W1 +: W1];
  end
  round_robin_arbiter #(.REQUESTERS(REQUESTERS)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .onehot_o(arb_onehot),
    .id_o    (arb_id),
    .valid_o (arb_valid)
  );
  // next-state and output decode; outputs depend on state only, so reset clears them at once
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    gnt_d = gnt_q;
    sel0_d = sel0_q;
    sel1_d = sel1_q;
    rej_d = rej_q;
    cnt_d = cnt_q;
    flags_d = flags_q;
    grant = '0;
    cmp_selector0 = '0;
    cmp_selector1 = '0;
    rsp_valid = 1'b0;
    rsp_id = '0;
    rsp_eq = 1'b0;
    rsp_gt = 1'b0;
    rsp_lt = 1'b0;
    rsp_error = 1'b0;
    busy = state_q != IDLE;
    case (state_q)
      IDLE: if (arb_valid) begin
        id_d = arb_id;
        gnt_d = arb_onehot;
        sel0_d = sel0_v[arb_id];
        sel1_d = sel1_v[arb_id];
        rej_d = sel0_v[arb_id] == W0'(SEL_NO_LOAD) || sel1_v[arb_id] == W1'(SEL_NO_LOAD);
        flags_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        grant = gnt_q;
        cmp_selector0 = rej_q ? W0'(SEL_NO_LOAD) : sel0_q;
        cmp_selector1 = rej_q ? W1'(SEL_NO_LOAD) : sel1_q;
        cnt_d = CW'(RESULT_LATENCY - 1);
        ptr_d = id_q == IW'(REQUESTERS - 1) ? '0 : id_q + 1'b1;
        state_d = rej_q ? RESPOND : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          flags_d[FLAG_EQ] = cmp_eq;
          flags_d[FLAG_GT] = cmp_gt;
          flags_d[FLAG_LT] = cmp_lt;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        rsp_id = id_q;
        rsp_eq = flags_q[FLAG_EQ];
        rsp_gt = flags_q[FLAG_GT];
        rsp_lt = flags_q[FLAG_LT];
        rsp_error = rej_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any transaction in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      gnt_q <= '0;
      sel0_q <= '0;
      sel1_q <= '0;
      rej_q <= 1'b0;
      cnt_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      gnt_q <= gnt_d;
      sel0_q <= sel0_d;
      sel1_q <= sel1_d;
      rej_q <= rej_d;
      cnt_q <= cnt_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_comparitor_scheduler.sv
// tb_comparitor_scheduler: random requests against a transaction-level scheduling model
module tb_comparitor_scheduler;
  localparam int LAT = 2;
  logic clock, reset_n;
  logic [3:0] req_valid, grant, req_b, grant_b;
  logic [11:0] req_sel0, req_sel1, sel0_b, sel1_b;
  logic [2:0] cmp_selector0, cmp_selector1, cs0_b, cs1_b;
  logic cmp_eq, cmp_gt, cmp_lt, eq_b, gt_b, lt_b;
  logic rsp_valid, rsp_eq, rsp_gt, rsp_lt, rsp_error, busy;
  logic rv_b, reqb_eq, reqb_gt, reqb_lt, err_b, busy_b;
  logic [1:0] rsp_id, id_b;
  int checks, errors;
  int d0 [8], d1 [8];
  logic [2:0] h0 [LAT], h1 [LAT];
  logic [2:0] h0b, h1b;
  logic [17:0] outs, outs_b;
  logic [3:0] pend;
  logic [2:0] s0v [4], s1v [4];
  int m_iss, m_resp, m_ptr, m_id;
  logic m_rej, rst_done;
  logic [2:0] m_s0, m_s1, m_flags;

  comparitor_scheduler #(.REQUESTERS(4), .COUNT0(4), .COUNT1(4), .RESULT_LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_sel0(req_sel0),
    .req_sel1(req_sel1), .grant(grant), .cmp_selector0(cmp_selector0),
    .cmp_selector1(cmp_selector1), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt),
    .rsp_lt(rsp_lt), .rsp_error(rsp_error), .busy(busy));

  comparitor_scheduler #(.REQUESTERS(4), .COUNT0(4), .COUNT1(4), .RESULT_LATENCY(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .req_valid(req_b), .req_sel0(sel0_b),
    .req_sel1(sel1_b), .grant(grant_b), .cmp_selector0(cs0_b),
    .cmp_selector1(cs1_b), .cmp_eq(eq_b), .cmp_gt(gt_b), .cmp_lt(lt_b),
    .rsp_valid(rv_b), .rsp_id(id_b), .rsp_eq(reqb_eq), .rsp_gt(reqb_gt),
    .rsp_lt(reqb_lt), .rsp_error(err_b), .busy(busy_b));

  assign outs = {grant, cmp_selector0, cmp_selector1, rsp_valid, rsp_id,
                 rsp_eq, rsp_gt, rsp_lt, rsp_error, busy};
  assign outs_b = {grant_b, cs0_b, cs1_b, rv_b, id_b, reqb_eq, reqb_gt, reqb_lt, err_b, busy_b};

  always #5 clock = ~clock;

  // comparitor unit models: result appears LAT cycles after the selectors, all-ones otherwise
  always @(posedge clock) begin
    h0[0] <= cmp_selector0;
    h1[0] <= cmp_selector1;
    for (int k = 1; k < LAT; k++) begin
      h0[k] <= h0[k-1];
      h1[k] <= h1[k-1];
    end
    h0b <= cs0_b;
    h1b <= cs1_b;
  end
  always_comb begin
    {cmp_eq, cmp_gt, cmp_lt} = 3'b111;
    if (h0[LAT-1] != 0 && h1[LAT-1] != 0)
      {cmp_eq, cmp_gt, cmp_lt} = {d0[h0[LAT-1]] == d1[h1[LAT-1]],
                                  d0[h0[LAT-1]] > d1[h1[LAT-1]],
                                  d0[h0[LAT-1]] < d1[h1[LAT-1]]};
    {eq_b, gt_b, lt_b} = 3'b111;
    if (h0b != 0 && h1b != 0)
      {eq_b, gt_b, lt_b} = {d0[h0b] == d1[h1b], d0[h0b] > d1[h1b], d0[h0b] < d1[h1b]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] rv, input int p);
    int r;
    r = -1;
    for (int k = 3; k >= 0; k--) if (rv[(p + k) % 4]) r = (p + k) % 4;
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = pend[i];
      req_sel0[i*3 +: 3] = s0v[i];
      req_sel1[i*3 +: 3] = s1v[i];
    end
  endtask

  initial begin
    logic [3:0] eg;
    logic [2:0] es0, es1, ef;
    logic erv, ebusy;
    logic [1:0] eid;
    clock = 0;
    reset_n = 1;
    checks = 0;
    errors = 0;
    req_valid = 0; req_sel0 = 0; req_sel1 = 0;
    req_b = 0; sel0_b = 0; sel1_b = 0;
    pend = 0;
    rst_done = 0;
    for (int i = 0; i < 4; i++) begin s0v[i] = 0; s1v[i] = 0; end
    for (int i = 0; i < 8; i++) begin d0[i] = $urandom_range(3); d1[i] = $urandom_range(3); end
    d0[3] = 3;
    d1[1] = 1;
    #1 reset_n = 0;
    repeat (2) @(negedge clock);
    check("reset_outs", 32'(outs), 0);
    check("reset_outs_lat1", 32'(outs_b), 0);
    reset_n = 1;
    req_b = 4'b0100;
    sel0_b[6 +: 3] = 3'd3;
    sel1_b[6 +: 3] = 3'd1;
    @(negedge clock);
    check("lat1_issue", {grant_b, cs0_b, cs1_b, busy_b}, {4'b0100, 3'd3, 3'd1, 1'b1});
    req_b = 0;
    @(negedge clock);
    check("lat1_wait", {cs0_b, cs1_b, rv_b, busy_b}, {3'd0, 3'd0, 1'b0, 1'b1});
    @(negedge clock);
    check("lat1_rsp", {rv_b, id_b, reqb_eq, reqb_gt, reqb_lt, err_b}, {1'b1, 2'd2, 4'b0100});
    @(negedge clock);
    check("lat1_idle", 32'(outs_b), 0);
    m_iss = -1; m_resp = -1; m_ptr = 0; m_id = 0; m_rej = 0;
    m_s0 = 0; m_s1 = 0; m_flags = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clock);
      reset_n = 1;
      eg = t == m_iss ? 4'(1 << m_id) : 4'b0;
      es0 = t == m_iss && !m_rej ? m_s0 : 3'd0;
      es1 = t == m_iss && !m_rej ? m_s1 : 3'd0;
      erv = t == m_resp;
      eid = erv ? 2'(m_id) : 2'd0;
      ef = erv ? m_flags : 3'd0;
      ebusy = t >= m_iss && t <= m_resp;
      check("cycle", 32'(outs), 32'({eg, es0, es1, erv, eid, ef, erv & m_rej, ebusy}));
      if (t == m_iss) pend[m_id] = 0;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          if (t < 60 || $urandom_range(2) == 0) begin
            pend[i] = 1;
            s0v[i] = 3'(t < 60 ? $urandom_range(4, 1) : $urandom_range(4));
            s1v[i] = 3'(t < 60 ? $urandom_range(4, 1) : $urandom_range(4));
          end
        end else if (t >= 60 && $urandom_range(15) == 0) pend[i] = 0;
      end
      drive();
      if (t > m_resp && req_valid != 0) begin
        m_id = pick(req_valid, m_ptr);
        m_s0 = s0v[m_id];
        m_s1 = s1v[m_id];
        m_rej = m_s0 == 0 || m_s1 == 0;
        m_flags = m_rej ? 3'b000 : {d0[m_s0] == d1[m_s1], d0[m_s0] > d1[m_s1], d0[m_s0] < d1[m_s1]};
        m_iss = t + 1;
        m_resp = m_rej ? t + 2 : t + 2 + LAT;
        m_ptr = (m_id + 1) % 4;
      end
      if (!rst_done && t >= 800 && t > m_iss && t < m_resp && !m_rej) begin
        #1 reset_n = 0;
        #1 check("async_reset_outs", 32'(outs), 0);
        m_iss = -1;
        m_resp = -1;
        m_ptr = 0;
        rst_done = 1;
      end
    end
    check("reset_in_wait_hit", 32'(rst_done), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
